// File: rtl/frog_collision_ctrl.sv
// Per-frame frog/car overlap detection plus the lives counter and the
// hit -> freeze -> respawn / game-over sequencing for the frogger core.
module frog_collision_ctrl #(
  parameter int LANE1_Y     = 64,
  parameter int LANE2_Y     = 128,
  parameter int LANE3_Y     = 192,
  parameter int LANE4_Y     = 256,
  parameter int CAR_W       = 32,
  parameter int CAR_H       = 32,
  parameter int FROG_W      = 32,
  parameter int FROG_H      = 32,
  parameter int HIT_FRAMES  = 60,
  parameter int START_LIVES = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       frame_tick,
  input  logic [9:0] car_x1,
  input  logic [9:0] car_x2,
  input  logic [9:0] car_x3,
  input  logic [9:0] car_x4,
  input  logic [9:0] frog_x,
  input  logic [9:0] frog_y,
  input  logic       start,
  output logic       hit_pulse,
  output logic [1:0] hit_lane,
  output logic       frog_freeze,
  output logic       respawn,
  output logic [1:0] lives,
  output logic       game_over
);

  typedef enum logic [1:0] {
    ST_ALIVE,
    ST_HIT,
    ST_RESPAWN,
    ST_GAME_OVER
  } state_t;

  localparam logic [10:0] CAR_W_V   = 11'(CAR_W);
  localparam logic [10:0] CAR_H_V   = 11'(CAR_H);
  localparam logic [10:0] FROG_W_V  = 11'(FROG_W);
  localparam logic [10:0] FROG_H_V  = 11'(FROG_H);
  localparam logic [7:0]  HIT_CNT_V = 8'(HIT_FRAMES);
  localparam logic [1:0]  LIVES_V   = 2'(START_LIVES);

  // X distances wrap modulo 1024 so cars straddling the screen edge still hit;
  // Y uses 11 bits so lane bottom / frog bottom never truncate.
  function automatic logic lane_overlap(input logic [9:0]  fx,
                                        input logic [9:0]  fy,
                                        input logic [9:0]  cx,
                                        input logic [10:0] ly);
    logic [9:0]  d_fc;
    logic [9:0]  d_cf;
    logic [10:0] fy_w;
    logic        x_hit;
    logic        y_hit;
    d_fc  = fx - cx;
    d_cf  = cx - fx;
    fy_w  = {1'b0, fy};
    x_hit = ({1'b0, d_fc} < CAR_W_V) || ({1'b0, d_cf} < FROG_W_V);
    y_hit = (fy_w < (ly + CAR_H_V)) && (ly < (fy_w + FROG_H_V));
    return x_hit && y_hit;
  endfunction

  function automatic logic [1:0] lowest_lane(input logic [3:0] vec);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (vec[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [1:0] lives_dec_sat(input logic [1:0] l);
    return (l == 2'd0) ? 2'd0 : l - 2'd1;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       lives_q, lives_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       hit_lane_q, hit_lane_d;

  logic [3:0][9:0]  car_x_p0_q, car_x_p0_d;
  logic [9:0]       frog_x_p0_q, frog_x_p0_d;
  logic [9:0]       frog_y_p0_q, frog_y_p0_d;
  logic             vld_p0_q, vld_p0_d;
  logic [3:0]       hit_vec_p1_q, hit_vec_p1_d;
  logic             vld_p1_q, vld_p1_d;
  logic             hit_accept;

  assign hit_accept = (state_q == ST_ALIVE) && vld_p1_q && (|hit_vec_p1_q);

  // Stage p0: sample positions on the frame tick (only ALIVE ticks are valid)
  always_comb begin
    car_x_p0_d  = car_x_p0_q;
    frog_x_p0_d = frog_x_p0_q;
    frog_y_p0_d = frog_y_p0_q;
    if (frame_tick) begin
      car_x_p0_d  = {car_x4, car_x3, car_x2, car_x1};
      frog_x_p0_d = frog_x;
      frog_y_p0_d = frog_y;
    end
    vld_p0_d = frame_tick && (state_q == ST_ALIVE) && !hit_accept;
  end

  // Stage p1: per-lane overlap vector
  always_comb begin
    hit_vec_p1_d[0] = lane_overlap(frog_x_p0_q, frog_y_p0_q, car_x_p0_q[0], 11'(LANE1_Y));
    hit_vec_p1_d[1] = lane_overlap(frog_x_p0_q, frog_y_p0_q, car_x_p0_q[1], 11'(LANE2_Y));
    hit_vec_p1_d[2] = lane_overlap(frog_x_p0_q, frog_y_p0_q, car_x_p0_q[2], 11'(LANE3_Y));
    hit_vec_p1_d[3] = lane_overlap(frog_x_p0_q, frog_y_p0_q, car_x_p0_q[3], 11'(LANE4_Y));
    vld_p1_d        = vld_p0_q;
  end

  always_ff @(posedge CLK) begin
    car_x_p0_q   <= car_x_p0_d;
    frog_x_p0_q  <= frog_x_p0_d;
    frog_y_p0_q  <= frog_y_p0_d;
    hit_vec_p1_q <= hit_vec_p1_d;
  end

  // Stage p2: FSM consumes the registered hit vector
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    cnt_d      = cnt_q;
    hit_lane_d = hit_lane_q;
    unique case (state_q)
      ST_ALIVE: begin
        if (hit_accept) begin
          hit_lane_d = lowest_lane(hit_vec_p1_q);
          lives_d    = lives_dec_sat(lives_q);
          if (lives_q <= 2'd1) begin
            state_d = ST_GAME_OVER;
          end else begin
            cnt_d   = HIT_CNT_V;
            state_d = ST_HIT;
          end
        end
      end
      ST_HIT: begin
        if (frame_tick) begin
          if (cnt_q <= 8'd1) state_d = ST_RESPAWN;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      ST_RESPAWN: state_d = ST_ALIVE;
      ST_GAME_OVER: begin
        if (start) begin
          lives_d = LIVES_V;
          state_d = ST_RESPAWN;
        end
      end
      default: state_d = ST_ALIVE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_ALIVE;
      lives_q    <= LIVES_V;
      cnt_q      <= 8'd0;
      hit_lane_q <= 2'd0;
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      cnt_q      <= cnt_d;
      hit_lane_q <= hit_lane_d;
      vld_p0_q   <= vld_p0_d;
      vld_p1_q   <= vld_p1_d;
    end
  end

  assign hit_pulse   = hit_accept;
  assign hit_lane    = hit_lane_q;
  assign lives       = lives_q;
  assign frog_freeze = (state_q != ST_ALIVE);
  assign respawn     = (state_q == ST_RESPAWN);
  assign game_over   = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_frog_collision_ctrl.sv
// Directed bench for frog_collision_ctrl: table of single-frame overlap
// vectors plus hand-written hit/respawn/game-over/reset sequences.
module tb_frog_collision_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       frame_tick;
  logic [9:0] car_x1, car_x2, car_x3, car_x4;
  logic [9:0] frog_x, frog_y;
  logic       start;
  logic       hit_pulse;
  logic [1:0] hit_lane;
  logic       frog_freeze;
  logic       respawn;
  logic [1:0] lives;
  logic       game_over;

  always #5 CLK = ~CLK;

  frog_collision_ctrl dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .frame_tick (frame_tick),
    .car_x1     (car_x1),
    .car_x2     (car_x2),
    .car_x3     (car_x3),
    .car_x4     (car_x4),
    .frog_x     (frog_x),
    .frog_y     (frog_y),
    .start      (start),
    .hit_pulse  (hit_pulse),
    .hit_lane   (hit_lane),
    .frog_freeze(frog_freeze),
    .respawn    (respawn),
    .lives      (lives),
    .game_over  (game_over)
  );

  typedef struct {
    logic [9:0] c1, c2, c3, c4, fx, fy;
    logic       exp_hit;
    logic [1:0] exp_lane;
  } vec_t;

  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic set_pos(input logic [9:0] c1, input logic [9:0] c2, input logic [9:0] c3,
                         input logic [9:0] c4, input logic [9:0] fx, input logic [9:0] fy);
    car_x1 = c1; car_x2 = c2; car_x3 = c3; car_x4 = c4;
    frog_x = fx; frog_y = fy;
  endtask

  // One frame tick; hp[k] = hit_pulse sampled k+1 cycles after the tick cycle,
  // rs = number of cycles respawn was seen, frz = frog_freeze 3 cycles later.
  task automatic tick(output logic [2:0] hp, output int rs, output logic frz);
    @(negedge CLK);
    frame_tick = 1'b1;
    @(negedge CLK);
    frame_tick = 1'b0;
    hp[0] = hit_pulse; rs = int'(respawn);
    @(negedge CLK);
    hp[1] = hit_pulse; rs += int'(respawn);
    @(negedge CLK);
    hp[2] = hit_pulse; rs += int'(respawn);
    frz = frog_freeze;
  endtask

  task automatic run_ticks(input int n, output int pulses, output int rs_total);
    logic [2:0] hp;
    int         rs;
    logic       frz;
    pulses   = 0;
    rs_total = 0;
    for (int i = 0; i < n; i++) begin
      tick(hp, rs, frz);
      if (hp != 3'b000) pulses++;
      rs_total += rs;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] hp;
    int         rs;
    logic       frz;
    int         pulses;
    int         rs_total;

    vecs[0]  = '{10'd110, 10'd600, 10'd600, 10'd600, 10'd100,  10'd64,  1'b1, 2'd0};
    vecs[1]  = '{10'd600, 10'd1010, 10'd600, 10'd600, 10'd5,   10'd128, 1'b1, 2'd1};
    vecs[2]  = '{10'd600, 10'd1010, 10'd600, 10'd600, 10'd20,  10'd128, 1'b0, 2'd0};
    vecs[3]  = '{10'd110, 10'd600, 10'd600, 10'd600, 10'd142,  10'd64,  1'b0, 2'd0};
    vecs[4]  = '{10'd110, 10'd600, 10'd600, 10'd600, 10'd78,   10'd64,  1'b0, 2'd0};
    vecs[5]  = '{10'd110, 10'd600, 10'd600, 10'd600, 10'd79,   10'd64,  1'b1, 2'd0};
    vecs[6]  = '{10'd600, 10'd600, 10'd290, 10'd600, 10'd300,  10'd208, 1'b1, 2'd2};
    vecs[7]  = '{10'd600, 10'd600, 10'd300, 10'd300, 10'd300,  10'd224, 1'b0, 2'd0};
    vecs[8]  = '{10'd600, 10'd600, 10'd300, 10'd300, 10'd300,  10'd225, 1'b1, 2'd3};
    vecs[9]  = '{10'd300, 10'd300, 10'd300, 10'd300, 10'd300,  10'd400, 1'b0, 2'd0};
    vecs[10] = '{10'd0,   10'd600, 10'd600, 10'd600, 10'd0,    10'd32,  1'b0, 2'd0};
    vecs[11] = '{10'd1020, 10'd600, 10'd600, 10'd600, 10'd1000, 10'd33, 1'b1, 2'd0};

    RST_N = 1'b0; frame_tick = 1'b0; start = 1'b0;
    set_pos(10'd110, 10'd600, 10'd600, 10'd600, 10'd100, 10'd64);
    do_reset();

    check("reset_hit_pulse", hit_pulse, 0);
    check("reset_hit_lane", hit_lane, 0);
    check("reset_freeze", frog_freeze, 0);
    check("reset_respawn", respawn, 0);
    check("reset_lives", lives, 3);
    check("reset_game_over", game_over, 0);

    for (int v = 0; v < 12; v++) begin
      do_reset();
      set_pos(vecs[v].c1, vecs[v].c2, vecs[v].c3, vecs[v].c4, vecs[v].fx, vecs[v].fy);
      tick(hp, rs, frz);
      check($sformatf("vec%0d_pulse_pattern", v), hp, vecs[v].exp_hit ? 3'b010 : 3'b000);
      check($sformatf("vec%0d_lives", v), lives, vecs[v].exp_hit ? 2 : 3);
      check($sformatf("vec%0d_freeze", v), frz, vecs[v].exp_hit);
      if (vecs[v].exp_hit) check($sformatf("vec%0d_lane", v), hit_lane, vecs[v].exp_lane);
    end

    // Hit in lane 3, overlap held through HIT, then respawn after 60 ticks
    do_reset();
    set_pos(10'd600, 10'd600, 10'd290, 10'd600, 10'd300, 10'd208);
    tick(hp, rs, frz);
    check("seqC_first_hit", hp, 3'b010);
    check("seqC_lane", hit_lane, 2);
    run_ticks(59, pulses, rs_total);
    check("seqC_no_hit_in_HIT", pulses, 0);
    check("seqC_no_early_respawn", rs_total, 0);
    check("seqC_lives_held", lives, 2);
    check("seqC_still_frozen", frog_freeze, 1);
    tick(hp, rs, frz);
    check("seqC_respawn_once", rs, 1);
    check("seqC_no_pulse_on_respawn", hp, 3'b000);
    check("seqC_unfrozen", frz, 0);
    tick(hp, rs, frz);
    check("seqC_next_tick_hit", hp, 3'b010);
    check("seqC_lives_1", lives, 1);
    run_ticks(30, pulses, rs_total);
    check("seqC_mid_hit_no_pulse", pulses + rs_total, 0);
    check("seqC_mid_hit_freeze", frog_freeze, 1);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("async_rst_lives", lives, 3);
    check("async_rst_freeze", frog_freeze, 0);
    check("async_rst_lane", hit_lane, 0);
    check("async_rst_game_over", game_over, 0);
    check("async_rst_hit_pulse", hit_pulse, 0);
    check("async_rst_respawn", respawn, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Three hits to game over, then restart
    do_reset();
    set_pos(10'd600, 10'd1010, 10'd600, 10'd600, 10'd5, 10'd128);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("start_alive_respawn", respawn, 0);
    check("start_alive_lives", lives, 3);
    check("start_alive_freeze", frog_freeze, 0);
    for (int k = 0; k < 3; k++) begin
      tick(hp, rs, frz);
      check($sformatf("go_hit%0d_pulse", k), hp, 3'b010);
      check($sformatf("go_hit%0d_lives", k), lives, 32'(2 - k));
      if (k < 2) begin
        run_ticks(60, pulses, rs_total);
        check($sformatf("go_hit%0d_respawn", k), rs_total, 1);
        check($sformatf("go_hit%0d_pulses_in_hit", k), pulses, 0);
      end
    end
    check("go_game_over", game_over, 1);
    check("go_freeze", frog_freeze, 1);
    run_ticks(65, pulses, rs_total);
    check("go_no_activity", pulses + rs_total, 0);
    check("go_lives_zero", lives, 0);
    check("go_still_over", game_over, 1);
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("restart_respawn", respawn, 1);
    check("restart_lives", lives, 3);
    check("restart_game_over", game_over, 0);
    @(negedge CLK);
    check("restart_respawn_one_cycle", respawn, 0);
    check("restart_unfrozen", frog_freeze, 0);
    tick(hp, rs, frz);
    check("restart_hit", hp, 3'b010);
    check("restart_lives_2", lives, 2);

    // Frog in no lane, cars sweeping through every X
    do_reset();
    pulses = 0;
    for (int i = 0; i < 2048; i++) begin
      set_pos(10'(i), 10'(i + 256), 10'(i + 512), 10'(i + 768), 10'd500, 10'd400);
      tick(hp, rs, frz);
      if (hp != 3'b000) pulses++;
    end
    check("sweep_no_hits", pulses, 0);
    check("sweep_lives", lives, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
